// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet transmitter.
package router_pkg;

    localparam int HDR_ADDR_W = 2;
    localparam int HDR_LEN_W  = 6;

    localparam logic [HDR_ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        SEND_HDR,
        SEND_PL,
        SEND_PAR,
        GAP
    } state_t;

    // Header byte carries the payload length in the upper bits and the destination below it.
    function automatic logic [7:0] pack_header(input logic [HDR_LEN_W-1:0]  len,
                                               input logic [HDR_ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload store: written while loading, read combinationally while sending.
module router_pkt_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clock,
    input  logic          wr_en_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a whole payload, then streams header, payload and
// parity into the router while honouring its busy stall.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [5:0] cmd_len,
    input  logic [1:0] cmd_addr,
    input  logic       cmd_corrupt,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] tx_data,
    output logic       cmd_err,
    output logic       tx_done,
    output logic       tx_busy
);

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    state_t                  state_q, state_d;
    logic [HDR_LEN_W-1:0]    len_q, len_d;
    logic [HDR_ADDR_W-1:0]   addr_q, addr_d;
    logic                    corrupt_q, corrupt_d;
    logic [7:0]              parity_q, parity_d;
    logic [5:0]              wptr_q, wptr_d;
    logic [5:0]              rptr_q, rptr_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    pkt_valid_q, pkt_valid_d;
    logic                    cmd_err_q, cmd_err_d;
    logic                    tx_done_q, tx_done_d;

    logic                    buf_we;
    logic [7:0]              buf_rdata;
    logic [7:0]              wire_parity;

    router_pkt_buf #(
        .DEPTH (MAX_LEN + 1),
        .AW    (6)
    ) u_buf (
        .clock   (clock),
        .wr_en_i (buf_we),
        .waddr_i (wptr_q),
        .wdata_i (pl_data),
        .raddr_i (rptr_q),
        .rdata_o (buf_rdata)
    );

    assign wire_parity = corrupt_q ? ~parity_q : parity_q;

    // Next-state logic; wire outputs only move on an edge where the router is not busy.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        corrupt_d   = corrupt_q;
        parity_d    = parity_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        gap_d       = gap_q;
        tx_data_d   = tx_data_q;
        pkt_valid_d = pkt_valid_q;
        cmd_err_d   = 1'b0;
        tx_done_d   = 1'b0;
        buf_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_addr == ILLEGAL_ADDR) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        len_d     = cmd_len;
                        addr_d    = cmd_addr;
                        corrupt_d = cmd_corrupt;
                        parity_d  = pack_header(cmd_len, cmd_addr);
                        wptr_d    = '0;
                        state_d   = (cmd_len != '0) ? LOAD : ARM;
                    end
                end
            end
            LOAD: begin
                if (pl_valid) begin
                    buf_we   = 1'b1;
                    wptr_d   = wptr_q + 6'd1;
                    parity_d = parity_q ^ pl_data;
                    if (wptr_q == len_q - 6'd1) begin
                        state_d = ARM;
                    end
                end
            end
            ARM: begin
                if (!busy) begin
                    tx_data_d   = pack_header(len_q, addr_q);
                    pkt_valid_d = 1'b1;
                    rptr_d      = '0;
                    state_d     = SEND_HDR;
                end
            end
            SEND_HDR: begin
                if (!busy) begin
                    if (len_q != '0) begin
                        tx_data_d = buf_rdata;
                        rptr_d    = 6'd1;
                        state_d   = SEND_PL;
                    end else begin
                        tx_data_d   = wire_parity;
                        pkt_valid_d = 1'b0;
                        state_d     = SEND_PAR;
                    end
                end
            end
            SEND_PL: begin
                if (!busy) begin
                    if (rptr_q != len_q) begin
                        tx_data_d = buf_rdata;
                        rptr_d    = rptr_q + 6'd1;
                    end else begin
                        tx_data_d   = wire_parity;
                        pkt_valid_d = 1'b0;
                        state_d     = SEND_PAR;
                    end
                end
            end
            SEND_PAR: begin
                if (!busy) begin
                    tx_data_d = 8'h00;
                    tx_done_d = 1'b1;
                    gap_d     = GW'(GAP_CYCLES);
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_q <= GW'(1)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= IDLE;
            len_q       <= '0;
            addr_q      <= '0;
            corrupt_q   <= 1'b0;
            parity_q    <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            gap_q       <= '0;
            tx_data_q   <= 8'h00;
            pkt_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            corrupt_q   <= corrupt_d;
            parity_q    <= parity_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            gap_q       <= gap_d;
            tx_data_q   <= tx_data_d;
            pkt_valid_q <= pkt_valid_d;
            cmd_err_q   <= cmd_err_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign pl_ready  = (state_q == LOAD);
    assign tx_busy   = (state_q != IDLE);
    assign pkt_valid = pkt_valid_q;
    assign tx_data   = tx_data_q;
    assign cmd_err   = cmd_err_q;
    assign tx_done   = tx_done_q;

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet transmitter sitting directly upstream of router_top; drives its pkt_valid/data_in input port.
- Accepts a packet command (length, destination, corrupt flag) plus payload bytes from a host-side stream.
- Buffers the whole payload, then serialises header, payload and parity while honouring the router's busy stall.
- Once a packet starts, pkt_valid never drops until the parity byte, so the router never sees a starved mid-packet gap.

Parameters:
MAX_LEN, 63, largest payload length; buffer depth = 64 entries, 6-bit length field.
GAP_CYCLES, 2, idle cycles forced after the parity byte is consumed before the next command is accepted.

Ports:
clock  input  1  single clock; all logic on rising edge
resetn  input  1  synchronous, active-low reset
cmd_valid  input  1  packet command offered
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at rising edge
cmd_len  input  6  payload byte count, 0..63
cmd_addr  input  2  destination port 0..2; 3 is illegal
cmd_corrupt  input  1  1 = transmit inverted parity (error injection)
pl_valid  input  1  payload byte offered
pl_ready  output  1  payload byte accepted when pl_valid & pl_ready at rising edge
pl_data  input  8  payload byte
busy  input  1  router busy; a wire byte is consumed only at a rising edge where busy==0
pkt_valid  output  1  to router pkt_valid; high for header and payload, low for parity
tx_data  output  8  to router data_in
cmd_err  output  1  one-cycle pulse: command rejected (addr==3)
tx_done  output  1  one-cycle pulse: parity byte consumed
tx_busy  output  1  state != IDLE

Behaviour:
- Reset (resetn==0 at a rising edge, including mid-packet): state IDLE. Outputs: pkt_valid=0, tx_data=0x00, cmd_err=0, tx_done=0, tx_busy=0. Buffer pointers, length, parity and gap counter all 0. Buffer contents are don't-care.
- cmd_ready=1 only in IDLE. pl_ready=1 only in LOAD. Both are combinational from state.
- pkt_valid, tx_data, cmd_err and tx_done are registered.
- Header byte = {cmd_len, cmd_addr}. Parity = XOR of header and all payload bytes. Wire parity = corrupt ? ~parity : parity.
- IDLE, on command accept:
  - addr==3: cmd_err=1 next cycle; stay IDLE; nothing transmitted.
  - otherwise: latch len/addr/corrupt; parity<=header; wptr<=0. Go to LOAD if len>0, else ARM.
- LOAD: each accepted byte is written to buf[wptr]; wptr++; parity^=byte. The edge that accepts byte len goes to ARM. Source stalls (pl_valid=0) are tolerated indefinitely.
- ARM: at the first edge with busy==0, tx_data<=header, pkt_valid<=1, rptr<=0; go to SEND_HDR.
- SEND_HDR, SEND_PL and SEND_PAR: tx_data and pkt_valid hold unchanged on every edge where busy==1. No byte is ever dropped or duplicated.
- SEND_HDR, edge with busy==0:
  - len>0: tx_data<=buf[0], rptr<=1; go to SEND_PL.
  - len==0: tx_data<=wire parity, pkt_valid<=0; go to SEND_PAR.
- SEND_PL, edge with busy==0:
  - rptr<len: tx_data<=buf[rptr], rptr++.
  - rptr==len: tx_data<=wire parity, pkt_valid<=0; go to SEND_PAR.
- SEND_PAR, edge with busy==0: tx_data<=0x00, tx_done=1 next cycle, gap counter<=GAP_CYCLES; go to GAP.
- GAP: decrement each cycle; at 0 go to IDLE. busy is ignored in GAP.
- Wire bytes per packet = len+2.
- Latency with busy==0 throughout:
  - header appears 1 cycle after the last payload byte is accepted (LOAD->ARM->SEND_HDR);
  - then one byte per cycle;
  - cmd_ready returns GAP_CYCLES+1 cycles after parity appears.
- cmd_valid outside IDLE and pl_valid outside LOAD are ignored.
- cmd_err and tx_done are never high in the same cycle (mutually exclusive states).

Decomposition:
- Shared package router_pkg:
  - state enum (IDLE, LOAD, ARM, SEND_HDR, SEND_PL, SEND_PAR, GAP)
  - HDR_ADDR_W=2, HDR_LEN_W=6
  - ILLEGAL_ADDR=2'b11
  - header-pack function
- One sub-module router_pkt_buf: 64x8 register array with synchronous write and asynchronous read, indexed by wptr/rptr.

Test Plan:
1. len=3, addr=1, payload 0x11,0x22,0x33, corrupt=0, busy=0 -> wire 0x0D(pv=1),0x11,0x22,0x33(pv=1),0x0D(pv=0), then tx_done pulse.
2. Same packet with corrupt=1 -> parity byte 0xF2; all other bytes identical.
3. len=0, addr=2 -> wire 0x02(pv=1), 0x02(pv=0); LOAD is skipped.
4. cmd_addr=3 -> cmd_err pulses 1 cycle; pkt_valid stays 0; next legal command is accepted immediately.
5. Scenario 1 with busy=1 for 3 cycles while 0x22 is on tx_data -> 0x22 held 4 cycles, consumed once; sequence unchanged.
6. len=63, addr=0 with random payload, reset asserted while payload byte 20 is on the wire -> next cycle pkt_valid=0, tx_data=0x00, cmd_ready=1. Rerun to completion -> header 0xFC, 65 wire bytes, correct parity.
